// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-fetch sequencer for a single-port, combinational-read
// instruction ROM. Owns the fetch PC, drives the ROM word address, captures
// each returned word together with its PC into a small FIFO, and presents the
// FIFO head to decode over a valid/ready handshake. A redirect from execute
// flushes the FIFO and reloads the PC. A misaligned PC, or a PC outside the
// ROM window, parks the sequencer in FAULT until the next redirect.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   fetch_en       in   1 = fetching permitted, 0 = hold PC and stop pushing
//   redirect_valid in   one-cycle pulse: load redirect_pc, flush the FIFO
//   redirect_pc    in   redirect byte address
//   imem_addr      out  ROM word address (combinational from the fetch PC)
//   imem_inst      in   ROM read data for imem_addr, same cycle
//   out_valid      out  FIFO head holds an instruction
//   out_ready      in   decode accepts the head this cycle
//   out_inst       out  head instruction
//   out_pc         out  byte PC of the head instruction
//   fault          out  fetch PC misaligned or outside the ROM window
//   fetch_pc       out  current fetch PC (debug)
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
   parameter int          ADDR_W  = 11,
   parameter logic [31:0] BASE_PC = 32'h0040_0000,
   parameter int          DEPTH   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [31:0]       out_pc,
   output logic              fault,
   output logic [31:0]       fetch_pc
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [31:0]      ROM_BYTES = 32'd4 << ADDR_W;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FAULT = 1'b1;

   // PC is fetchable when word aligned and inside [BASE_PC, BASE_PC+ROM_BYTES).
   // The unsigned subtraction makes PCs below BASE_PC wrap to huge offsets.
   function automatic logic pc_fetchable(input logic [31:0] pc);
      logic [31:0] off;
      off = pc - BASE_PC;
      return (off < ROM_BYTES) && (pc[1:0] == 2'b00);
   endfunction

   logic [0:0]       state_r;
   logic [31:0]      fetch_pc_r;
   logic [CNT_W-1:0] count_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [31:0]      inst_mem_r [DEPTH];
   logic [31:0]      pc_mem_r   [DEPTH];

   logic [31:0] off_s;
   logic        in_range_s;
   logic        pop_s;
   logic        space_s;
   logic        push_s;
   logic [0:0]  state_n_s;
   logic [31:0] pc_n_s;

   assign off_s      = fetch_pc_r - BASE_PC;
   assign in_range_s = pc_fetchable(fetch_pc_r);
   assign imem_addr  = off_s[ADDR_W+1:2];

   assign out_valid = (count_r != {CNT_W{1'b0}});
   assign out_inst  = inst_mem_r[rd_ptr_r];
   assign out_pc    = pc_mem_r[rd_ptr_r];
   assign fault     = (state_r == ST_FAULT);
   assign fetch_pc  = fetch_pc_r;

   assign pop_s   = out_valid && out_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign space_s = (count_r < DEPTH_C) || pop_s;

   // Next fetch PC, next state and push decision; redirect overrides everything.
   always_comb begin
      push_s    = 1'b0;
      state_n_s = state_r;
      pc_n_s    = fetch_pc_r;
      if (redirect_valid) begin
         pc_n_s    = redirect_pc;
         state_n_s = ST_RUN;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (fetch_en) begin
                  if (!in_range_s) begin
                     state_n_s = ST_FAULT;
                  end else if (space_s) begin
                     push_s = 1'b1;
                     pc_n_s = fetch_pc_r + 32'd4;
                  end else begin
                     pc_n_s = fetch_pc_r;
                  end
               end else begin
                  state_n_s = state_r;
               end
            end
            ST_FAULT: begin
               state_n_s = ST_FAULT;
            end
            default: begin
               state_n_s = ST_FAULT;
            end
         endcase
      end
   end

   // Fetch PC and sequencer state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_RUN;
         fetch_pc_r <= BASE_PC;
      end else begin
         state_r    <= state_n_s;
         fetch_pc_r <= pc_n_s;
      end
   end

   // Instruction FIFO: storage, pointers and occupancy; redirect flushes it and
   // silently discards any pop offered in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r  <= {CNT_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            inst_mem_r[i] <= 32'd0;
            pc_mem_r[i]   <= 32'd0;
         end
      end else if (redirect_valid) begin
         count_r  <= {CNT_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (push_s) begin
            inst_mem_r[wr_ptr_r] <= imem_inst;
            pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
            wr_ptr_r             <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

   localparam logic [31:0] BASE = 32'h0040_0000;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [10:0] imem_addr;
   logic [31:0] imem_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        fault;
   logic [31:0] fetch_pc;

   int checks;
   int failures;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   imem_fetch_ctrl #(.ADDR_W(11), .BASE_PC(BASE), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_inst(imem_inst),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_pc(out_pc),
      .fault(fault), .fetch_pc(fetch_pc)
   );

   // Distinctive ROM content: word address appears twice with fixed tags.
   function automatic logic [31:0] rom_word(input logic [10:0] a);
      return {5'h15, a, 5'h0A, a};
   endfunction

   function automatic logic [31:0] rom_at_pc(input logic [31:0] pc);
      logic [31:0] off;
      off = pc - BASE;
      return rom_word(off[12:2]);
   endfunction

   assign imem_inst = rom_word(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every accepted handshake must match the queue head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !redirect_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=%h required=none", out_pc);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("sb_pc", out_pc, mon_exp);
            chk("sb_inst", out_inst, rom_at_pc(mon_exp));
         end
      end
   end

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      fetch_en = 1'b1;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      tick();
      tick();
      chk("rst_fetch_pc", fetch_pc, BASE);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);

      // Stall from reset: FIFO fills with PC0, PC1 and the PC holds at +8.
      rst_n = 1'b1;
      chk("addr_c0", 32'(imem_addr), 32'd0);
      tick();
      chk("addr_c1", 32'(imem_addr), 32'd1);
      chk("first_valid", 32'(out_valid), 32'd1);
      chk("first_pc", out_pc, BASE);
      tick();
      chk("addr_c2", 32'(imem_addr), 32'd2);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_fetch_pc", fetch_pc, 32'h0040_0008);
         chk("stall_head_pc", out_pc, BASE);
         chk("stall_head_inst", out_inst, rom_word(11'd0));
      end

      // Resume: full FIFO pushes and pops together, no gaps or duplicates.
      for (int i = 0; i < 6; i++) exp_q.push_back(BASE + 32'(4 * i));
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("resume_fetch_pc", fetch_pc, 32'h0040_0020);

      // Redirect while full with a pop offered: head PC6 is dropped.
      redirect_valid = 1'b1;
      redirect_pc = 32'h0040_0100;
      tick();
      redirect_valid = 1'b0;
      chk("redir_valid", 32'(out_valid), 32'd0);
      chk("redir_addr", 32'(imem_addr), 32'h040);
      chk("redir_fault", 32'(fault), 32'd0);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h0040_0100 + 32'(4 * i));
      tick();
      chk("redir_first_pc", out_pc, 32'h0040_0100);
      for (int i = 0; i < 4; i++) tick();

      // Misaligned redirect faults and stops fetching.
      redirect_valid = 1'b1;
      redirect_pc = 32'h0040_0102;
      tick();
      redirect_valid = 1'b0;
      chk("mis_fetch_pc", fetch_pc, 32'h0040_0102);
      chk("mis_valid0", 32'(out_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mis_fault", 32'(fault), 32'd1);
         chk("mis_valid", 32'(out_valid), 32'd0);
         chk("mis_hold_pc", fetch_pc, 32'h0040_0102);
      end

      // Redirect back to word 0 clears the fault.
      redirect_valid = 1'b1;
      redirect_pc = BASE;
      tick();
      redirect_valid = 1'b0;
      chk("clr_fault", 32'(fault), 32'd0);
      chk("clr_addr", 32'(imem_addr), 32'd0);
      exp_q.push_back(BASE);
      exp_q.push_back(BASE + 32'd4);
      tick();
      chk("clr_first_pc", out_pc, BASE);
      tick();
      tick();

      // End of ROM: last two words delivered, then fault at the window edge.
      redirect_valid = 1'b1;
      redirect_pc = 32'h0040_1FF8;
      tick();
      redirect_valid = 1'b0;
      chk("end_addr", 32'(imem_addr), 32'h7FE);
      exp_q.push_back(32'h0040_1FF8);
      exp_q.push_back(32'h0040_1FFC);
      tick();
      tick();
      tick();
      chk("end_fault", 32'(fault), 32'd1);
      chk("end_fetch_pc", fetch_pc, 32'h0040_2000);
      chk("end_valid", 32'(out_valid), 32'd0);
      tick();
      chk("end_hold_pc", fetch_pc, 32'h0040_2000);
      chk("end_no_push", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-stream with a full FIFO.
      out_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = BASE;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_fault", 32'(fault), 32'd0);
      chk("arst_fetch_pc", fetch_pc, BASE);
      chk("arst_out_pc", out_pc, 32'd0);
      chk("arst_out_inst", out_inst, 32'd0);
      tick();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
